// File: rtl/equiv_pkg.sv
// rtl/equiv_pkg.sv - shared types and width helpers for the equivalence checker
//
// Contents:
//   state_t : checker FSM state encoding (IDLE=0, SETTLE=1, CHECK=2, DONE=3).
//   cnt_w() : width of an error counter for an in_w-bit sweep.
//             2^in_w mismatches must fit without wrapping, which needs in_w+1 bits.
package equiv_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  function automatic int cnt_w(input int in_w);
    return in_w + 1;
  endfunction

endpackage

// File: rtl/equiv_checker_if.sv
// rtl/equiv_checker_if.sv - bundle between the checker and its harness/DUT pair
//
// Parameters: IN_W (stimulus width), OUT_W (compared output width).
// Signals:
//   start, stop_on_err : sweep control, driven by the harness.
//   q_a, q_b           : outputs of the two implementations under comparison.
//   stim               : vector driven to both implementations.
//   busy, done, pass   : sweep status.
//   err_valid, err_vec : one-cycle mismatch report and the failing vector.
//   first_err_vec      : first failing vector of the current sweep.
//   err_count          : mismatches in the current sweep.
// Modports: master = checker side, slave = harness side.
interface equiv_checker_if
  import equiv_pkg::*;
#(
  parameter int IN_W  = 3,
  parameter int OUT_W = 1
);

  logic                     start;
  logic                     stop_on_err;
  logic [OUT_W-1:0]         q_a;
  logic [OUT_W-1:0]         q_b;
  logic [IN_W-1:0]          stim;
  logic                     busy;
  logic                     done;
  logic                     pass;
  logic                     err_valid;
  logic [IN_W-1:0]          err_vec;
  logic [IN_W-1:0]          first_err_vec;
  logic [cnt_w(IN_W)-1:0]   err_count;

  modport master (
    input  start, stop_on_err, q_a, q_b,
    output stim, busy, done, pass, err_valid, err_vec, first_err_vec, err_count
  );

  modport slave (
    output start, stop_on_err, q_a, q_b,
    input  stim, busy, done, pass, err_valid, err_vec, first_err_vec, err_count
  );

endinterface

// File: rtl/equiv_vec_gen.sv
// rtl/equiv_vec_gen.sv - stimulus vector counter for the equivalence sweep
//
// Ports:
//   clk, rst_n : clock, synchronous active-low reset.
//   clr        : return the vector to zero (start of a sweep).
//   inc        : advance to the next vector.
//   vec        : current vector.
//   last       : vec is all-ones (final vector of the sweep).
module equiv_vec_gen #(
  parameter int IN_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            inc,
  output logic [IN_W-1:0] vec,
  output logic            last
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      vec <= '0;
    end else if (inc) begin
      vec <= vec + IN_W'(1);
    end
  end

  assign last = &vec;

endmodule

// File: rtl/equiv_checker.sv
// rtl/equiv_checker.sv - exhaustive equivalence sweep of two implementations
//
// Parameters:
//   IN_W   : stimulus width; every one of 2^IN_W vectors is applied.
//   OUT_W  : width of the compared outputs.
//   SETTLE : cycles each vector is held before its compare cycle (>= 1).
// Ports:
//   clk, rst_n : clock, synchronous active-low reset.
//   bus        : equiv_checker_if.master (control, DUT outputs, stimulus, status).
module equiv_checker
  import equiv_pkg::*;
#(
  parameter int IN_W   = 3,
  parameter int OUT_W  = 1,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  equiv_checker_if.master  bus
);

  localparam int CW   = cnt_w(IN_W);
  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SC_W-1:0] SETTLE_RELOAD = SC_W'(SETTLE - 1);

  state_t            state_q, state_d;
  logic [SC_W-1:0]   settle_q;
  logic              stop_q;
  logic [CW-1:0]     err_cnt_q;
  logic [IN_W-1:0]   first_q;
  logic              ev_q;
  logic [IN_W-1:0]   evec_q;

  logic              vec_clr, vec_inc, settle_load, sweep_clr, check_hit;
  logic              mismatch;
  logic [IN_W-1:0]   vec;
  logic              vec_last;

  equiv_vec_gen #(.IN_W(IN_W)) u_vec_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (vec_clr),
    .inc   (vec_inc),
    .vec   (vec),
    .last  (vec_last)
  );

  assign mismatch = (bus.q_a != bus.q_b);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    vec_clr     = 1'b0;
    vec_inc     = 1'b0;
    settle_load = 1'b0;
    sweep_clr   = 1'b0;
    check_hit   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d     = S_SETTLE;
          vec_clr     = 1'b1;
          settle_load = 1'b1;
          sweep_clr   = 1'b1;
        end
      end
      S_SETTLE: begin
        if (settle_q == '0) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        check_hit = mismatch;
        // The sweep ends on the all-ones vector, or early on a mismatch
        // when stop-on-error was latched at start.
        if (vec_last || (mismatch && stop_q)) begin
          state_d = S_DONE;
        end else begin
          state_d     = S_SETTLE;
          vec_inc     = 1'b1;
          settle_load = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle_q  <= '0;
      stop_q    <= 1'b0;
      err_cnt_q <= '0;
      first_q   <= '0;
      ev_q      <= 1'b0;
      evec_q    <= '0;
    end else begin
      // Report lags the compare by one cycle and names the vector just checked.
      ev_q <= check_hit;
      if (check_hit) begin
        evec_q <= vec;
      end

      if (settle_load) begin
        settle_q <= SETTLE_RELOAD;
      end else if (state_q == S_SETTLE && settle_q != '0) begin
        settle_q <= settle_q - SC_W'(1);
      end

      if (sweep_clr) begin
        err_cnt_q <= '0;
        first_q   <= '0;
        stop_q    <= bus.stop_on_err;
      end else if (check_hit) begin
        err_cnt_q <= err_cnt_q + CW'(1);
        if (err_cnt_q == '0) begin
          first_q <= vec;
        end
      end
    end
  end

  assign bus.stim          = vec;
  assign bus.busy          = (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign bus.done          = (state_q == S_DONE);
  assign bus.pass          = (state_q == S_DONE) && (err_cnt_q == '0);
  assign bus.err_valid     = ev_q;
  assign bus.err_vec       = evec_q;
  assign bus.first_err_vec = first_q;
  assign bus.err_count     = err_cnt_q;

endmodule

// File: tb/tb_equiv_checker.sv
// tb/tb_equiv_checker.sv - self-checking bench for equiv_checker
module tb_equiv_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic        stop_on_err;
  logic        sel;
  logic [7:0]  mask3;
  logic [15:0] mask4;
  logic [1:0]  xv4;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          exp_errs[$];

  equiv_checker_if #(.IN_W(3), .OUT_W(1)) bus3();
  equiv_checker_if #(.IN_W(4), .OUT_W(2)) bus4();

  equiv_checker #(.IN_W(3), .OUT_W(1), .SETTLE(1)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  equiv_checker #(.IN_W(4), .OUT_W(2), .SETTLE(3)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  assign bus3.start       = start & ~sel;
  assign bus4.start       = start & sel;
  assign bus3.stop_on_err = stop_on_err;
  assign bus4.stop_on_err = stop_on_err;
  assign bus3.q_a         = ^bus3.stim;
  assign bus3.q_b         = bus3.q_a ^ mask3[bus3.stim];
  assign bus4.q_a         = bus4.stim[1:0];
  assign bus4.q_b         = bus4.q_a ^ (mask4[bus4.stim] ? xv4 : 2'b00);

  logic [3:0] g_stim, g_err_vec, g_first;
  logic [4:0] g_cnt;
  logic       g_busy, g_done, g_pass, g_ev;
  assign g_stim    = sel ? bus4.stim          : {1'b0, bus3.stim};
  assign g_err_vec = sel ? bus4.err_vec       : {1'b0, bus3.err_vec};
  assign g_first   = sel ? bus4.first_err_vec : {1'b0, bus3.first_err_vec};
  assign g_cnt     = sel ? bus4.err_count     : {1'b0, bus3.err_count};
  assign g_busy    = sel ? bus4.busy          : bus3.busy;
  assign g_done    = sel ? bus4.done          : bus3.done;
  assign g_pass    = sel ? bus4.pass          : bus3.pass;
  assign g_ev      = sel ? bus4.err_valid     : bus3.err_valid;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk the vectors in order, collect the failing ones, stop
  // at the first if requested; each applied vector costs settle+1 cycles.
  task automatic ref_sweep(input int nvec, input int settle, input logic [15:0] m,
                           input bit stop, output int busy, output int cnt,
                           output int first, output int last);
    exp_errs.delete();
    cnt = 0; first = 0; last = nvec - 1;
    for (int v = 0; v < nvec; v++) begin
      if (m[v]) begin
        exp_errs.push_back(v);
        if (cnt == 0) first = v;
        cnt++;
        if (stop) begin
          last = v;
          break;
        end
      end
    end
    busy = (last + 1) * (settle + 1);
  endtask

  task automatic do_sweep(input string tag, input bit s, input logic [15:0] m,
                          input logic [1:0] xv, input bit stop, input int repulse,
                          input int e_busy, input int e_cnt, input int e_first,
                          input int e_pass, input int e_last);
    int nb, cyc, stim_bad, list_bad, settle, nvec, d0, d1, d2, d3;
    bit prev_busy;
    int got[$];
    settle = s ? 3 : 1;
    nvec   = s ? 16 : 8;
    ref_sweep(nvec, settle, m, stop, d0, d1, d2, d3);
    sel = s; mask3 = m[7:0]; mask4 = m; xv4 = xv; stop_on_err = stop; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stop_on_err = ~stop;
    chk({tag, " busy_rise"}, int'(g_busy), 1);
    chk({tag, " stim_first"}, int'(g_stim), 0);
    nb = 0; cyc = 0; stim_bad = 0; prev_busy = 1'b0;
    forever begin
      if (g_ev) got.push_back(int'(g_err_vec));
      if (g_done || cyc >= 400) break;
      if (g_busy) begin
        if (int'(g_stim) != nb / (settle + 1)) stim_bad++;
        nb++;
      end
      prev_busy = g_busy;
      start = (cyc == repulse);
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    chk({tag, " done_seen"}, int'(g_done), 1);
    chk({tag, " busy_at_done"}, int'(g_busy), 0);
    chk({tag, " busy_before_done"}, int'(prev_busy), 1);
    chk({tag, " busy_cycles"}, nb, e_busy);
    chk({tag, " stim_steps_bad"}, stim_bad, 0);
    chk({tag, " err_pulses"}, got.size(), exp_errs.size());
    list_bad = 0;
    for (int i = 0; i < got.size() && i < exp_errs.size(); i++)
      if (got[i] != exp_errs[i]) list_bad++;
    chk({tag, " err_vec_list_bad"}, list_bad, 0);
    chk({tag, " err_count"}, int'(g_cnt), e_cnt);
    chk({tag, " first_err_vec"}, int'(g_first), e_first);
    chk({tag, " pass"}, int'(g_pass), e_pass);
    chk({tag, " stim_last"}, int'(g_stim), e_last);
    @(posedge clk); #1;
    chk({tag, " done_held"}, int'(g_done), 1);
    chk({tag, " stim_held"}, int'(g_stim), e_last);
  endtask

  typedef struct {
    bit          s;
    logic [15:0] m;
    logic [1:0]  xv;
    bit          stop;
    int          repulse;
    int          e_busy, e_cnt, e_first, e_pass, e_last;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int rb, rc, rf, rl, cyc;
    bit rs, rstop;
    logic [15:0] rm;
    logic [1:0] rxv;

    tbl[0] = '{1'b0, 16'h0000, 2'd0, 1'b0, -1, 16, 0,  0, 1, 7};
    tbl[1] = '{1'b0, 16'h0020, 2'd0, 1'b0, -1, 16, 1,  5, 0, 7};
    tbl[2] = '{1'b0, 16'h0044, 2'd0, 1'b1, -1,  6, 1,  2, 0, 2};
    tbl[3] = '{1'b1, 16'hFFFF, 2'd3, 1'b0, -1, 64, 16, 0, 0, 15};
    tbl[4] = '{1'b0, 16'h0000, 2'd0, 1'b0,  4, 16, 0,  0, 1, 7};
    tbl[5] = '{1'b1, 16'h8000, 2'd2, 1'b1, -1, 64, 1, 15, 0, 15};
    tbl[6] = '{1'b0, 16'h0081, 2'd0, 1'b0, -1, 16, 2,  0, 0, 7};

    rst_n = 1'b0; start = 1'b0; stop_on_err = 1'b0; sel = 1'b0;
    mask3 = '0; mask4 = '0; xv4 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst stim", int'(bus3.stim), 0);
    chk("rst busy", int'(bus3.busy), 0);
    chk("rst done", int'(bus3.done), 0);
    chk("rst pass", int'(bus3.pass), 0);
    chk("rst err_valid", int'(bus3.err_valid), 0);
    chk("rst err_vec", int'(bus3.err_vec), 0);
    chk("rst first_err_vec", int'(bus3.first_err_vec), 0);
    chk("rst err_count", int'(bus3.err_count), 0);
    chk("rst4 busy", int'(bus4.busy), 0);
    chk("rst4 done", int'(bus4.done), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      do_sweep($sformatf("tbl%0d", i), tbl[i].s, tbl[i].m, tbl[i].xv, tbl[i].stop,
               tbl[i].repulse, tbl[i].e_busy, tbl[i].e_cnt, tbl[i].e_first,
               tbl[i].e_pass, tbl[i].e_last);

    // Reset in the middle of a sweep, after one error has been recorded.
    sel = 1'b0; mask3 = 8'h02; stop_on_err = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (bus3.stim != 3'd3 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("mid reached stim3", int'(bus3.stim), 3);
    chk("mid err_count before reset", int'(bus3.err_count), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid rst stim", int'(bus3.stim), 0);
    chk("mid rst busy", int'(bus3.busy), 0);
    chk("mid rst done", int'(bus3.done), 0);
    chk("mid rst pass", int'(bus3.pass), 0);
    chk("mid rst err_valid", int'(bus3.err_valid), 0);
    chk("mid rst err_vec", int'(bus3.err_vec), 0);
    chk("mid rst first_err_vec", int'(bus3.first_err_vec), 0);
    chk("mid rst err_count", int'(bus3.err_count), 0);
    start = 1'b1;
    @(posedge clk); #1;
    chk("rst wins over start", int'(bus3.busy), 0);
    start = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle after reset", int'(bus3.busy), 0);
    do_sweep("restart", 1'b0, 16'h0000, 2'd0, 1'b0, -1, 16, 0, 0, 1, 7);

    for (int i = 0; i < 24; i++) begin
      rs    = 1'($urandom_range(0, 1));
      rm    = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rm = '0;
      if (!rs) rm[15:8] = '0;
      rxv   = 2'($urandom_range(1, 3));
      rstop = 1'($urandom_range(0, 1));
      ref_sweep(rs ? 16 : 8, rs ? 3 : 1, rm, rstop, rb, rc, rf, rl);
      do_sweep($sformatf("rnd%0d", i), rs, rm, rxv, rstop,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1,
               rb, rc, rf, (rc == 0) ? 1 : 0, rl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
